// File: rtl/instr_boot_loader.sv
// Boot loader: assembles a little-endian word stream into instruction memory
// and holds the core in reset until the announced number of words is written.
//
// state | meaning
// HDR   | waiting for the word-count header byte
// BYTES | collecting the four bytes of the current word
// WRITE | one-cycle write strobe of the assembled word
// RUN   | load complete, core released; left only by reset
module instr_boot_loader #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256,
  parameter int BASE_ADDR = 212
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] mem_addr,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_write_val,
  output logic        core_reset,
  output logic        load_done,
  output logic [7:0]  words_loaded
);

  typedef enum logic [1:0] {HDR, BYTES, WRITE, RUN} state_t;

  state_t                 state;
  logic [1:0]             byte_idx;
  logic [7:0]             word_idx;
  logic [7:0]             n_words;
  logic [MEM_WIDTH-1:0]   word_buf;
  logic                   xfer;
  logic [31:0]            word_addr;

  assign xfer        = rx_valid & rx_ready;
  assign mem_read_en = 1'b0;
  assign word_addr   = (32'(BASE_ADDR) + {24'd0, word_idx}) % 32'(MEM_SIZE);

  // Outputs are registered alongside the state so each one is valid in the
  // same cycle as the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HDR;
      byte_idx      <= 2'd0;
      word_idx      <= 8'd0;
      n_words       <= 8'd0;
      word_buf      <= '0;
      words_loaded  <= 8'd0;
      rx_ready      <= 1'b1;
      mem_write_en  <= 1'b0;
      mem_addr      <= 32'd0;
      mem_write_val <= 32'd0;
      core_reset    <= 1'b1;
      load_done     <= 1'b0;
    end else begin
      mem_write_en  <= 1'b0;
      mem_addr      <= 32'd0;
      mem_write_val <= 32'd0;
      case (state)
        HDR: begin
          if (xfer) begin
            n_words <= rx_data;
            if (rx_data == 8'd0) begin
              state      <= RUN;
              rx_ready   <= 1'b0;
              core_reset <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              state    <= BYTES;
              byte_idx <= 2'd0;
            end
          end
        end
        BYTES: begin
          if (xfer) begin
            word_buf[8*byte_idx +: 8] <= rx_data;
            byte_idx                  <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state         <= WRITE;
              rx_ready      <= 1'b0;
              mem_write_en  <= 1'b1;
              mem_addr      <= word_addr;
              mem_write_val <= {rx_data, word_buf[23:0]};
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 8'd1;
          byte_idx     <= 2'd0;
          if (word_idx == n_words - 8'd1) begin
            state      <= RUN;
            core_reset <= 1'b0;
            load_done  <= 1'b1;
          end else begin
            word_idx <= word_idx + 8'd1;
            state    <= BYTES;
            rx_ready <= 1'b1;
          end
        end
        RUN: begin
          rx_ready <= 1'b0;
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule
